// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit sequencer: FSM encoding, default
// geometry and the frame-length helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SLOT_W   = 32;

  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_tx_shifter.sv
// Frame shift register: loads left/right samples MSB-aligned in their slots
// with zero padding below, then shifts out MSB first.
module i2s_tx_shifter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                msb
);

  localparam int FRAME_W = frame_bits(SLOT_W);
  localparam int PAD_W   = SLOT_W - SAMPLE_W;

  logic [FRAME_W-1:0] shift_reg;
  logic [SLOT_W-1:0]  left_slot;
  logic [SLOT_W-1:0]  right_slot;

  // Sample occupies the top SAMPLE_W bits of each slot; the rest is zero.
  for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_slot
    if (gi >= PAD_W) begin : g_data
      assign left_slot[gi]  = left[gi-PAD_W];
      assign right_slot[gi] = right[gi-PAD_W];
    end else begin : g_pad
      assign left_slot[gi]  = 1'b0;
      assign right_slot[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= {left_slot, right_slot};
    end else if (shift) begin
      shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
    end
  end

  assign msb = shift_reg[FRAME_W-1];

endmodule

// File: rtl/i2s_tx_sequencer.sv
// Philips-format I2S transmitter: one-entry sample holding register, BCLK /
// LRCLK generation from a tick enable, and frame sequencing with drain on stop.
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                en,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                s_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sd,
  output logic                underrun,
  output logic                busy
);

  localparam int FRAME_W = frame_bits(SLOT_W);
  localparam int CNT_W   = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W:0]   SLOT_CNT = (CNT_W + 1)'(SLOT_W);

  state_t              state_reg;
  logic                bclk_reg;
  logic                lrclk_reg;
  logic                sd_reg;
  logic                underrun_reg;
  logic                hold_full_reg;
  logic [SAMPLE_W-1:0] hold_left_reg;
  logic [SAMPLE_W-1:0] hold_right_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic                frame_load;
  logic                shift_step;
  logic                shift_msb;
  logic [CNT_W:0]      cnt_inc;
  logic [SAMPLE_W-1:0] load_left;
  logic [SAMPLE_W-1:0] load_right;

  assign cnt_inc = {1'b0, cnt_reg} + 1'b1;

  // Frame load happens on a tick either from IDLE or on the last falling
  // edge of a frame; ordinary falling edges advance the shifter.
  always_comb begin
    frame_load = 1'b0;
    shift_step = 1'b0;
    if (!rst && tick) begin
      case (state_reg)
        ST_IDLE: frame_load = en;
        ST_RUN: begin
          if (bclk_reg) begin
            if (cnt_reg == CNT_LAST) begin
              frame_load = en;
            end else begin
              shift_step = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // An empty holding register loads a silent frame.
  assign load_left  = hold_full_reg ? hold_left_reg  : '0;
  assign load_right = hold_full_reg ? hold_right_reg : '0;

  i2s_tx_shifter #(
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (frame_load),
    .shift (shift_step),
    .left  (load_left),
    .right (load_right),
    .msb   (shift_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      bclk_reg       <= 1'b0;
      lrclk_reg      <= 1'b1;
      sd_reg         <= 1'b0;
      underrun_reg   <= 1'b0;
      hold_full_reg  <= 1'b0;
      hold_left_reg  <= '0;
      hold_right_reg <= '0;
      cnt_reg        <= '0;
    end else begin
      underrun_reg <= 1'b0;

      if (s_valid && !hold_full_reg) begin
        hold_full_reg  <= 1'b1;
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
      end

      // A same-cycle transfer only refills hold for the following frame.
      if (frame_load) begin
        sd_reg    <= shift_msb;
        lrclk_reg <= 1'b0;
        cnt_reg   <= '0;
        if (hold_full_reg) begin
          hold_full_reg <= 1'b0;
        end else begin
          underrun_reg <= 1'b1;
        end
      end

      if (tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (en) begin
              state_reg <= ST_RUN;
            end
          end
          ST_RUN: begin
            bclk_reg <= !bclk_reg;
            if (bclk_reg) begin
              if (cnt_reg != CNT_LAST) begin
                sd_reg    <= shift_msb;
                cnt_reg   <= cnt_inc[CNT_W-1:0];
                lrclk_reg <= (cnt_inc >= SLOT_CNT);
              end else if (!en) begin
                sd_reg    <= shift_msb;
                lrclk_reg <= 1'b1;
                state_reg <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            bclk_reg <= !bclk_reg;
            if (bclk_reg) begin
              sd_reg    <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready   = !hold_full_reg;
  assign i2s_bclk  = bclk_reg;
  assign i2s_lrclk = lrclk_reg;
  assign i2s_sd    = sd_reg;
  assign underrun  = underrun_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Scoreboard bench: a tick-level frame model predicts pin behaviour and frame
// contents; an I2S receiver on the pins pops and compares whole frames.
module tb_i2s_tx_sequencer;

  localparam int SAMPLE_W  = 16;
  localparam int SLOT_W    = 16;
  localparam int FRAME_W   = 2 * SLOT_W;
  localparam int TICKS_FR  = 2 * FRAME_W;
  localparam int CLK_PER_T = 4;

  logic clk = 1'b0;
  logic rst, tick, en, s_valid;
  logic [SAMPLE_W-1:0] s_left, s_right;
  logic s_ready, i2s_bclk, i2s_lrclk, i2s_sd, underrun, busy;

  int checks = 0;
  int failures = 0;

  // Model state: mode 0=idle 1=running 2=draining
  int   m_mode, m_pos, m_dpos;
  logic m_full, m_underrun;
  logic [SAMPLE_W-1:0] m_l, m_r;
  logic [63:0] exp_q[$];

  // Receiver state
  int   rx_idx;
  logic rx_prev_lr, rx_prev_bclk;
  logic [63:0] rx_word;

  always #5 clk = ~clk;

  i2s_tx_sequencer #(
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .en        (en),
    .s_valid   (s_valid),
    .s_left    (s_left),
    .s_right   (s_right),
    .s_ready   (s_ready),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sd    (i2s_sd),
    .underrun  (underrun),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    return (64'(l) << (FRAME_W - SAMPLE_W)) | (64'(r) << (SLOT_W - SAMPLE_W));
  endfunction

  // Tick every CLK_PER_T clocks, changed well after the edge.
  initial begin
    int div;
    div = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #4;
      tick = (div == CLK_PER_T - 1);
      div = (div + 1) % CLK_PER_T;
    end
  end

  // Model update, per-cycle pin checks and frame receiver.
  initial begin
    logic old_full, fl, exp_bclk, exp_lr;
    logic [63:0] exp_word;
    m_mode = 0; m_pos = 0; m_dpos = 0; m_full = 1'b0; m_underrun = 1'b0;
    m_l = '0; m_r = '0;
    rx_idx = 0; rx_prev_lr = 1'b1; rx_prev_bclk = 1'b0; rx_word = '0;
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        m_mode = 0; m_pos = 0; m_dpos = 0; m_full = 1'b0; m_underrun = 1'b0;
        exp_q.delete();
        rx_idx = 0; rx_prev_lr = 1'b1; rx_prev_bclk = 1'b0;
      end else begin
        old_full = m_full;
        fl = 1'b0;
        if (tick) begin
          if (m_mode == 0) begin
            if (en) begin fl = 1'b1; m_mode = 1; m_pos = 0; end
          end else if (m_mode == 1) begin
            m_pos++;
            if (m_pos == TICKS_FR) begin
              if (en) begin fl = 1'b1; m_pos = 0; end
              else begin m_mode = 2; m_dpos = 0; end
            end
          end else begin
            m_dpos++;
            if (m_dpos == 2) m_mode = 0;
          end
        end
        m_underrun = fl && !old_full;
        if (fl) begin
          if (old_full) begin
            exp_q.push_back(frame_of(m_l, m_r));
            m_full = 1'b0;
          end else begin
            exp_q.push_back(64'd0);
          end
        end
        if (s_valid && !old_full) begin
          m_full = 1'b1; m_l = s_left; m_r = s_right;
        end
      end

      exp_bclk = (m_mode == 1) ? m_pos[0] : (m_mode == 2) ? m_dpos[0] : 1'b0;
      exp_lr   = (m_mode == 1) ? ((m_pos / 2) >= SLOT_W) : 1'b1;
      chk("bclk", i2s_bclk, exp_bclk);
      chk("lrclk", i2s_lrclk, exp_lr);
      chk("s_ready", s_ready, !m_full);
      chk("underrun", underrun, m_underrun);
      chk("busy", busy, m_mode != 0);
      if (m_mode == 0) chk("idle_sd", i2s_sd, 1'b0);

      if (!rst && i2s_bclk && !rx_prev_bclk) begin
        if (rx_idx > 0) begin
          rx_word = {rx_word[62:0], i2s_sd};
          rx_idx++;
          if (rx_idx == FRAME_W + 1) begin
            chk("frame_expected_present", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              exp_word = exp_q.pop_front();
              chk("frame_data", rx_word, exp_word);
            end
            rx_idx = 0;
          end
        end
        if (!i2s_lrclk && rx_prev_lr) begin
          rx_idx = 1;
          rx_word = '0;
        end
        rx_prev_lr = i2s_lrclk;
      end
      rx_prev_bclk = i2s_bclk;
    end
  end

  task automatic bound_fail(input string name, input logic reached);
    chk(name, reached, 1'b1);
  endtask

  task automatic push_sample(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    int n;
    n = 0;
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    bound_fail("push_wait", s_ready);
    s_valid = 1'b1; s_left = l; s_right = r;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_run_pos(input int p, input string name);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_pos == p) && n < 5000) begin @(negedge clk); n++; end
    bound_fail(name, m_mode == 1 && m_pos == p);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_mode != 0 && n < 5000) begin @(negedge clk); n++; end
    bound_fail(name, m_mode == 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic frame, stop requested mid-frame
    push_sample(16'hA5C3, 16'h0F0F);
    en = 1'b1;
    wait_run_pos(30, "basic_mid_frame");
    en = 1'b0;
    wait_idle("basic_drain");

    // Underrun: running with no samples
    en = 1'b1;
    repeat (3 * CLK_PER_T * TICKS_FR) @(negedge clk);

    // Back-pressure: source always valid
    for (int i = 0; i < 4 * CLK_PER_T * TICKS_FR; i++) begin
      s_valid = 1'b1; s_left = SAMPLE_W'($urandom); s_right = SAMPLE_W'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b0;

    // Random traffic with random run/stop
    for (int i = 0; i < 10 * CLK_PER_T * TICKS_FR; i++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      s_left = SAMPLE_W'($urandom); s_right = SAMPLE_W'($urandom);
      if ($urandom_range(0, 199) == 0) en = !en;
      @(negedge clk);
    end
    s_valid = 1'b0;
    en = 1'b1;

    // Sample arrives in the same clk as a frame load with hold empty
    n = 0;
    while (!(m_mode == 1 && m_pos == TICKS_FR - 1 && tick && !m_full) && n < 5000) begin
      @(negedge clk); n++;
    end
    bound_fail("load_collision_align", m_mode == 1 && m_pos == TICKS_FR - 1 && tick && !m_full);
    s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h5678;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2 * CLK_PER_T * TICKS_FR + 8) @(negedge clk);

    // Reset mid-frame at cnt=9
    wait_run_pos(18, "reset_align");
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("rst_bclk", i2s_bclk, 1'b0);
    chk("rst_lrclk", i2s_lrclk, 1'b1);
    chk("rst_sd", i2s_sd, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Restart reproduces the basic frame
    push_sample(16'hA5C3, 16'h0F0F);
    en = 1'b1;
    wait_run_pos(30, "restart_mid_frame");
    en = 1'b0;
    wait_idle("restart_drain");
    repeat (8) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("receiver_idle", 64'(rx_idx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
